// File: rtl/comp_4in_pkg.sv
// Shared constants for the comp_4in max-selector leaf.
package comp_4in_pkg;
  localparam int DEF_WIDTH = 19;
  localparam int INDEX_W   = 4;
endpackage

// File: rtl/comp_4in_comp_2in.sv
// Two-way unsigned max with one-hot tag; equality keeps the first operand.
module comp_2in
  import comp_4in_pkg::*;
#(
  parameter int p_width = DEF_WIDTH
) (
  input  logic [p_width-1:0] a_val,
  input  logic [INDEX_W-1:0] a_tag,
  input  logic [p_width-1:0] b_val,
  input  logic [INDEX_W-1:0] b_tag,
  output logic [p_width-1:0] max_val,
  output logic [INDEX_W-1:0] max_tag
);
  logic a_wins;

  assign a_wins  = (a_val >= b_val);
  assign max_val = a_wins ? a_val : b_val;
  assign max_tag = a_wins ? a_tag : b_tag;
endmodule

// File: rtl/comp_4in.sv
// Four-input unsigned max selector with one-hot winner index (priority a>b>c>d).
module comp_4in
  import comp_4in_pkg::*;
#(
  parameter int p_width   = DEF_WIDTH,
  parameter bit p_reg_out = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [p_width-1:0] i_a,
  input  logic [p_width-1:0] i_b,
  input  logic [p_width-1:0] i_c,
  input  logic [p_width-1:0] i_d,
  output logic [p_width-1:0] o_result,
  output logic [INDEX_W-1:0] o_index
);
  logic [p_width-1:0] ab_val, cd_val, fin_val;
  logic [INDEX_W-1:0] ab_tag, cd_tag, fin_tag;
  logic               nonzero;
  logic [INDEX_W-1:0] comb_index;

  comp_2in #(.p_width(p_width)) u_ab (
    .a_val(i_a), .a_tag(4'b0001), .b_val(i_b), .b_tag(4'b0010),
    .max_val(ab_val), .max_tag(ab_tag)
  );

  comp_2in #(.p_width(p_width)) u_cd (
    .a_val(i_c), .a_tag(4'b0100), .b_val(i_d), .b_tag(4'b1000),
    .max_val(cd_val), .max_tag(cd_tag)
  );

  // a/b side is the first operand so it keeps the win on equality
  comp_2in #(.p_width(p_width)) u_fin (
    .a_val(ab_val), .a_tag(ab_tag), .b_val(cd_val), .b_tag(cd_tag),
    .max_val(fin_val), .max_tag(fin_tag)
  );

  // all-zero inputs mean "no winner"; fin_val is already 0 in that case
  assign nonzero    = |{i_a, i_b, i_c, i_d};
  assign comb_index = nonzero ? fin_tag : '0;

  generate
    if (p_reg_out) begin : g_reg
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          o_result <= '0;
          o_index  <= '0;
        end else begin
          o_result <= fin_val;
          o_index  <= comb_index;
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = i_clk ^ i_rst_n;
      assign o_result       = fin_val;
      assign o_index        = comb_index;
    end
  endgenerate
endmodule

// File: tb/tb_comp_4in.sv
// Self-checking bench: combinational and registered comp_4in against a priority-max model.
module tb_comp_4in;
  localparam int W = 19;
  localparam logic [W-1:0] MAXV = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [W-1:0] c_res, r_res;
  logic [3:0]   c_idx, r_idx;
  int           n_chk = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  comp_4in #(.p_width(W), .p_reg_out(1'b0)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
    .o_result(c_res), .o_index(c_idx)
  );

  comp_4in #(.p_width(W), .p_reg_out(1'b1)) dut_r (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_c(c), .i_d(d),
    .o_result(r_res), .o_index(r_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scan in letter order; only a strictly larger value displaces the current
  // winner, so the lowest letter wins ties. All-zero gives no winner.
  function automatic void ref_model(input logic [W-1:0] va, vb, vc, vd,
                                    output logic [W-1:0] res, output logic [3:0] idx);
    logic [W-1:0] v [4];
    int best;
    v[0] = va; v[1] = vb; v[2] = vc; v[3] = vd;
    best = 0;
    for (int i = 1; i < 4; i++)
      if (v[i] > v[best]) best = i;
    res = v[best];
    idx = (res == 0) ? 4'b0000 : 4'(1 << best);
  endfunction

  // Drive at negedge, check comb output at once and registered output after the next posedge.
  task automatic apply(input logic [W-1:0] va, vb, vc, vd, input string tag);
    logic [W-1:0] er;
    logic [3:0]   ei;
    @(negedge clk);
    a = va; b = vb; c = vc; d = vd;
    ref_model(va, vb, vc, vd, er, ei);
    #1;
    chk({tag, "_cres"}, 32'(c_res), 32'(er));
    chk({tag, "_cidx"}, 32'(c_idx), 32'(ei));
    @(posedge clk);
    #1;
    chk({tag, "_rres"}, 32'(r_res), 32'(er));
    chk({tag, "_ridx"}, 32'(r_idx), 32'(ei));
  endtask

  initial begin
    logic [W-1:0] er;
    logic [3:0]   ei;

    // reset state of the registered variant
    #12;
    chk("rst_rres", 32'(r_res), 32'd0);
    chk("rst_ridx", 32'(r_idx), 32'd0);
    chk("rst_cidx", 32'(c_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed: max in each position
    apply(19'd10, 19'd40, 19'd25, 19'd3,  "maxb");
    chk("maxb_const", 32'(c_idx), 32'b0010);
    apply(19'd40, 19'd10, 19'd25, 19'd3,  "maxa");
    chk("maxa_const", 32'(c_idx), 32'b0001);
    apply(19'd10, 19'd25, 19'd40, 19'd3,  "maxc");
    chk("maxc_const", 32'(c_idx), 32'b0100);
    apply(19'd10, 19'd25, 19'd3,  19'd40, "maxd");
    chk("maxd_const", 32'(c_idx), 32'b1000);

    // all zero, then a single low bit on d
    apply('0, '0, '0, '0, "zero");
    chk("zero_const", 32'(c_idx), 32'b0000);
    apply('0, '0, '0, 19'd1, "d1");
    chk("d1_const", 32'(c_idx), 32'b1000);

    // ties
    apply(19'd9, 19'd9, 19'd9, 19'd9, "tie4");
    chk("tie4_const", 32'(c_idx), 32'b0001);
    apply(19'd50, 19'd50, 19'd100, 19'd100, "tiecd");
    chk("tiecd_const", 32'(c_idx), 32'b0100);
    chk("tiecd_cres_const", 32'(c_res), 32'd100);
    apply(19'd5, 19'd5, 19'd3, 19'd3, "tieab");
    chk("tieab_const", 32'(c_idx), 32'b0001);
    apply(19'd6, 19'd7, 19'd7, 19'd7, "tiebcd");
    chk("tiebcd_const", 32'(c_idx), 32'b0010);

    // width extremes
    apply(MAXV, MAXV - 1, MAXV - 1, MAXV - 1, "wide_a");
    chk("wide_a_const", 32'(c_idx), 32'b0001);
    apply('0, '0, '0, MAXV, "wide_d");
    chk("wide_d_const", 32'(c_res), 32'd524287);
    chk("wide_d_idx_const", 32'(c_idx), 32'b1000);

    // asynchronous reset mid-stream: registered clears at once, comb unaffected
    apply(19'd3, 19'd8, 19'd1, 19'd2, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    ref_model(a, b, c, d, er, ei);
    chk("async_rres", 32'(r_res), 32'd0);
    chk("async_ridx", 32'(r_idx), 32'd0);
    chk("async_cidx", 32'(c_idx), 32'(ei));
    chk("async_cres", 32'(c_res), 32'(er));
    @(negedge clk);
    rst_n = 1'b1;
    a = '0; b = 19'd7; c = '0; d = '0;
    #1;
    chk("post_rst_hold_ridx", 32'(r_idx), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_ridx", 32'(r_idx), 32'b0010);
    chk("post_rst_rres", 32'(r_res), 32'd7);

    // random regression, back-to-back vectors; mostly small ranges to force ties
    for (int n = 0; n < 10000; n++) begin
      logic [W-1:0] ra, rb, rc, rd;
      if (n % 8 == 7) begin
        ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); rd = W'($urandom);
      end else begin
        ra = W'($urandom_range(0, 3)); rb = W'($urandom_range(0, 3));
        rc = W'($urandom_range(0, 3)); rd = W'($urandom_range(0, 3));
      end
      apply(ra, rb, rc, rd, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
